pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives write-enable and flush/bubble controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use hazards, redirects on taken branch/jump, and freezes the pipe while data memory is busy, with a timeout.
- Sits beside the decode stage; all of its outputs go to the pipeline register modules.

---
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stall, branch/jump redirect, memory-wait freeze with timeout.
// Optional performance counters are enabled with `define PIPE_HAZARD_PERF_EN.
//
// state    | meaning
// RUN      | normal issue; hazards resolved combinationally each cycle
// MEM_WAIT | data memory busy; pipe frozen, wait counter running
// ERR      | memory timed out; pipe frozen until reset
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic       UsesRs_D,
  input  logic       UsesRt_D,
  input  logic       MemRead_E,
  input  logic [4:0] Rt_E,
  input  logic       BranchTaken_E,
  input  logic [1:0] Jump_E,
  input  logic       MemReq_M,
  input  logic       MemReady_M,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Write,
  output logic       ID_EX_Flush,
  output logic       EX_MEM_Write,
  output logic       Redirect,
  output logic [1:0] State,
  output logic       MemTimeout
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount,
  output logic [31:0] WaitCount
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             loaduse;
  logic             redir;
  logic             memwait;
  logic             frozen;

  assign loaduse = MemRead_E && (Rt_E != 5'd0) &&
                   ((UsesRs_D && (Rs_D == Rt_E)) || (UsesRt_D && (Rt_D == Rt_E)));
  assign redir   = BranchTaken_E || (Jump_E != 2'd0);
  assign memwait = MemReq_M && !MemReady_M;
  assign frozen  = (state_q == ERR) || memwait;
  assign State   = state_q;

  // Reset forces the run-time defaults so the pipe is released without a clock edge.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    Redirect     = 1'b0;
    if (reset) begin
      if (frozen) begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
      end else if (redir) begin
        Redirect    = 1'b1;
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end else if (loaduse) begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (memwait) begin
            state_q  <= MEM_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          // A dropped request counts as completion.
          if (!memwait) begin
            state_q  <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt >= TIMEOUT_C) begin
            state_q    <= ERR;
            MemTimeout <= 1'b1;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ERR:     state_q <= ERR;
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCount <= '0;
      FlushCount <= '0;
      WaitCount  <= '0;
    end else if (state_q != ERR) begin
      if (memwait)      WaitCount  <= WaitCount + 32'd1;
      else if (redir)   FlushCount <= FlushCount + 32'd1;
      else if (loaduse) StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
// Define PIPE_HAZARD_PERF_EN to also exercise the performance counters.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs_D, Rt_D, Rt_E;
  logic       UsesRs_D, UsesRt_D, MemRead_E, BranchTaken_E, MemReq_M, MemReady_M;
  logic [1:0] Jump_E;
  logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, Redirect;
  logic [1:0] State;
  logic       MemTimeout;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] StallCount, FlushCount, WaitCount;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: 0=RUN 1=MEM_WAIT 2=ERR, waited = cycles spent stalled on memory so far
  int   m_state;
  int   m_waited;
  logic m_to;

  // Control vector order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, Redirect}
  localparam logic [6:0] C_RUN    = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_REDIR  = 7'b1111111;
  localparam logic [6:0] C_STALL  = 7'b0001110;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .UsesRs_D(UsesRs_D), .UsesRt_D(UsesRt_D),
    .MemRead_E(MemRead_E), .Rt_E(Rt_E), .BranchTaken_E(BranchTaken_E), .Jump_E(Jump_E),
    .MemReq_M(MemReq_M), .MemReady_M(MemReady_M),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Write(EX_MEM_Write),
    .Redirect(Redirect), .State(State), .MemTimeout(MemTimeout)
`ifdef PIPE_HAZARD_PERF_EN
    , .StallCount(StallCount), .FlushCount(FlushCount), .WaitCount(WaitCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] act_ctrl();
    return {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, Redirect};
  endfunction

  function automatic logic [6:0] exp_ctrl();
    logic lu, rd, mw;
    lu = MemRead_E && (Rt_E != 0) && ((UsesRs_D && Rs_D == Rt_E) || (UsesRt_D && Rt_D == Rt_E));
    rd = BranchTaken_E || (Jump_E != 0);
    mw = MemReq_M && !MemReady_M;
    if (!reset) return C_RUN;
    if (m_state == 2 || mw) return C_FREEZE;
    if (rd) return C_REDIR;
    if (lu) return C_STALL;
    return C_RUN;
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_waited = 0;
    m_to     = 1'b0;
  endtask

  task automatic idle();
    Rs_D = 0; Rt_D = 0; Rt_E = 0; UsesRs_D = 0; UsesRt_D = 0; MemRead_E = 0;
    BranchTaken_E = 0; Jump_E = 0; MemReq_M = 0; MemReady_M = 0;
  endtask

  // Commit the current cycle into the model, then move to 1 time unit after the next rising edge.
  task automatic advance();
    logic mw;
    mw = MemReq_M && !MemReady_M;
    if (m_state == 0 && mw) begin
      m_state = 1; m_waited = 1;
    end else if (m_state == 1) begin
      if (!mw) begin
        m_state = 0; m_waited = 0;
      end else if (m_waited >= TO) begin
        m_state = 2; m_to = 1'b1;
      end else begin
        m_waited = (m_waited < 255) ? m_waited + 1 : 255;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    model_reset();
    #3;
    checks++;
    if (act_ctrl() !== C_RUN || State !== 2'd0 || MemTimeout !== 1'b0) begin
      errors++;
      $display("FAIL reset ctrl=%b exp=%b state=%0d exp=0 to=%b exp=0", act_ctrl(), C_RUN, State, MemTimeout);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    advance();
  endtask

  task automatic test_load_use();
    idle();
    MemRead_E = 1; Rt_E = 8; Rs_D = 8; UsesRs_D = 1;
    #2;
    checks++;
    if (act_ctrl() !== C_STALL || State !== 2'd0) begin
      errors++;
      $display("FAIL load_use ctrl=%b exp=%b state=%0d", act_ctrl(), C_STALL, State);
    end
    advance();
    MemRead_E = 0;
    #2;
    checks++;
    if (act_ctrl() !== C_RUN) begin
      errors++;
      $display("FAIL load_use_release ctrl=%b exp=%b", act_ctrl(), C_RUN);
    end
    advance();
  endtask

  task automatic test_zero_reg();
    idle();
    MemRead_E = 1; Rt_E = 0; Rs_D = 0; UsesRs_D = 1;
    #2;
    checks++;
    if (act_ctrl() !== C_RUN) begin
      errors++;
      $display("FAIL zero_reg ctrl=%b exp=%b", act_ctrl(), C_RUN);
    end
    advance();
    idle();
    MemRead_E = 1; Rt_E = 8; Rt_D = 8; UsesRt_D = 0;
    #2;
    checks++;
    if (act_ctrl() !== C_RUN) begin
      errors++;
      $display("FAIL unused_rt ctrl=%b exp=%b", act_ctrl(), C_RUN);
    end
    advance();
    UsesRt_D = 1;
    #2;
    checks++;
    if (act_ctrl() !== C_STALL) begin
      errors++;
      $display("FAIL rt_match ctrl=%b exp=%b", act_ctrl(), C_STALL);
    end
    advance();
    idle();
  endtask

  task automatic test_branch();
    idle();
    MemRead_E = 1; Rt_E = 8; Rs_D = 8; UsesRs_D = 1; BranchTaken_E = 1;
    #2;
    checks++;
    if (act_ctrl() !== C_REDIR) begin
      errors++;
      $display("FAIL branch_over_lu ctrl=%b exp=%b", act_ctrl(), C_REDIR);
    end
    advance();
    idle();
    Jump_E = 2'd2;
    #2;
    checks++;
    if (act_ctrl() !== C_REDIR) begin
      errors++;
      $display("FAIL jump ctrl=%b exp=%b", act_ctrl(), C_REDIR);
    end
    advance();
    idle();
  endtask

  task automatic test_mem_wait();
    idle();
    MemReq_M = 1; MemReady_M = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (act_ctrl() !== C_FREEZE || State !== ((i == 0) ? 2'd0 : 2'd1)) begin
        errors++;
        $display("FAIL mem_wait cyc=%0d ctrl=%b exp=%b state=%0d", i, act_ctrl(), C_FREEZE, State);
      end
      advance();
    end
    MemReady_M = 1;
    #2;
    checks++;
    if (act_ctrl() !== C_RUN || State !== 2'd1) begin
      errors++;
      $display("FAIL mem_ready ctrl=%b exp=%b state=%0d exp=1", act_ctrl(), C_RUN, State);
    end
    advance();
    idle();
    #2;
    checks++;
    if (State !== 2'd0) begin
      errors++;
      $display("FAIL mem_back_to_run state=%0d exp=0", State);
    end
    advance();
    // Request withdrawn while waiting behaves like completion.
    MemReq_M = 1;
    advance();
    MemReq_M = 0;
    #2;
    checks++;
    if (act_ctrl() !== C_RUN || State !== 2'd1) begin
      errors++;
      $display("FAIL req_drop ctrl=%b exp=%b state=%0d exp=1", act_ctrl(), C_RUN, State);
    end
    advance();
    #2;
    checks++;
    if (State !== 2'd0) begin
      errors++;
      $display("FAIL req_drop_run state=%0d exp=0", State);
    end
    advance();
  endtask

  task automatic test_timeout();
    idle();
    MemReq_M = 1; MemReady_M = 0;
    for (int i = 0; i <= TO; i++) begin
      #2;
      checks++;
      if (act_ctrl() !== C_FREEZE || State !== ((i == 0) ? 2'd0 : 2'd1) || MemTimeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait cyc=%0d ctrl=%b state=%0d to=%b", i, act_ctrl(), State, MemTimeout);
      end
      advance();
    end
    #2;
    checks++;
    if (act_ctrl() !== C_FREEZE || State !== 2'd2 || MemTimeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err ctrl=%b exp=%b state=%0d exp=2 to=%b exp=1", act_ctrl(), C_FREEZE, State, MemTimeout);
    end
    advance();
    MemReq_M = 0; MemReady_M = 1; BranchTaken_E = 1;
    #2;
    checks++;
    if (act_ctrl() !== C_FREEZE || State !== 2'd2) begin
      errors++;
      $display("FAIL err_sticky ctrl=%b exp=%b state=%0d exp=2", act_ctrl(), C_FREEZE, State);
    end
    advance();
    idle();
    MemReq_M = 1;
    reset = 1'b0;
    #1;
    checks++;
    if (act_ctrl() !== C_RUN || State !== 2'd0 || MemTimeout !== 1'b0) begin
      errors++;
      $display("FAIL async_reset ctrl=%b exp=%b state=%0d exp=0 to=%b exp=0", act_ctrl(), C_RUN, State, MemTimeout);
    end
    idle();
    model_reset();
    reset = 1'b1;
    advance();
  endtask

  task automatic test_random();
    int err_cycles = 0;
    for (int n = 0; n < 400; n++) begin
      if (m_state == 2 && ++err_cycles > 2) begin
        reset = 1'b0;
        model_reset();
        err_cycles = 0;
      end
      #1;
      reset = 1'b1;
      Rs_D = 5'($urandom_range(0, 3));
      Rt_D = 5'($urandom_range(0, 3));
      Rt_E = 5'($urandom_range(0, 3));
      UsesRs_D = 1'($urandom_range(0, 1));
      UsesRt_D = 1'($urandom_range(0, 1));
      MemRead_E = 1'($urandom_range(0, 1));
      BranchTaken_E = ($urandom_range(0, 7) == 0);
      Jump_E = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      MemReq_M = ($urandom_range(0, 3) == 0);
      MemReady_M = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (act_ctrl() !== exp_ctrl() || State !== m_state[1:0] || MemTimeout !== m_to) begin
        errors++;
        $display("FAIL random n=%0d ctrl=%b exp=%b state=%0d exp=%0d to=%b exp=%b",
                 n, act_ctrl(), exp_ctrl(), State, m_state, MemTimeout, m_to);
      end
      advance();
    end
    idle();
    reset = 1'b0;
    model_reset();
    #1;
    reset = 1'b1;
    advance();
  endtask

`ifdef PIPE_HAZARD_PERF_EN
  task automatic test_perf();
    idle();
    reset = 1'b0;
    model_reset();
    #1;
    reset = 1'b1;
    advance();
    for (int i = 0; i < 2; i++) begin
      MemRead_E = 1; Rt_E = 5; Rs_D = 5; UsesRs_D = 1;
      advance();
      idle();
      advance();
    end
    Jump_E = 2'd1;
    advance();
    idle();
    MemReq_M = 1;
    repeat (3) advance();
    MemReady_M = 1;
    advance();
    idle();
    advance();
    checks++;
    if (StallCount !== 32'd2 || FlushCount !== 32'd1 || WaitCount !== 32'd3) begin
      errors++;
      $display("FAIL perf stall=%0d exp=2 flush=%0d exp=1 wait=%0d exp=3", StallCount, FlushCount, WaitCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_random();
`ifdef PIPE_HAZARD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
